// File: rtl/gost89_pkg.sv
// Shared types, constants and the round-key ordering for the GOST 28147-89 core.
package gost89_pkg;

  typedef logic [63:0]  block_t;
  typedef logic [31:0]  half_t;
  typedef logic [255:0] key_t;
  typedef logic [511:0] sbox_t;

  typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

  localparam int ROUNDS = 32;
  localparam logic [5:0] LAST_CNT = 6'd32;

  // Encrypt reverses only the last eight rounds; decrypt reverses all but the first eight.
  function automatic logic [2:0] key_index(input logic [4:0] round, input logic mode);
    logic [2:0] pos;
    pos = round[2:0];
    if (mode == 1'b0) begin
      key_index = (round[4:3] == 2'd3) ? ~pos : pos;
    end else begin
      key_index = (round[4:3] == 2'd0) ? pos : ~pos;
    end
  endfunction

endpackage

// File: rtl/gost89_ecb_decrypt.sv
// Fixed-direction wrapper: GOST 28147-89 ECB decryption.
module gost89_ecb_decrypt (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         load_data,
  input  logic [511:0] sbox,
  input  logic [255:0] key,
  input  logic [63:0]  in,
  output logic [63:0]  out,
  output logic         busy
);

  gost89_ecb_unit u_unit (
    .clk       (clk),
    .reset_n   (reset_n),
    .mode      (1'b1),
    .load_data (load_data),
    .sbox      (sbox),
    .key       (key),
    .in        (in),
    .out       (out),
    .busy      (busy)
  );

endmodule

// File: rtl/gost89_ecb_encrypt.sv
// Fixed-direction wrapper: GOST 28147-89 ECB encryption.
module gost89_ecb_encrypt (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         load_data,
  input  logic [511:0] sbox,
  input  logic [255:0] key,
  input  logic [63:0]  in,
  output logic [63:0]  out,
  output logic         busy
);

  gost89_ecb_unit u_unit (
    .clk       (clk),
    .reset_n   (reset_n),
    .mode      (1'b0),
    .load_data (load_data),
    .sbox      (sbox),
    .key       (key),
    .in        (in),
    .out       (out),
    .busy      (busy)
  );

endmodule

// File: rtl/gost89_round.sv
// One GOST 28147-89 Feistel round: add key, S-box substitution, rotate by 11, xor and swap.
module gost89_round
  import gost89_pkg::*;
(
  input  half_t i_n1,
  input  half_t i_n2,
  input  half_t i_rkey,
  input  sbox_t i_sbox,
  output half_t o_n1,
  output half_t o_n2
);

  half_t       w_sum;
  half_t       w_sub;
  half_t       w_f;
  logic [63:0] w_row;
  logic [3:0]  w_nib;

  // Entry v of a row sits at the v-th nibble from the row MSB, i.e. bit offset 4*(15-v).
  always_comb begin
    w_sum = i_n1 + i_rkey;
    w_sub = 32'd0;
    w_row = 64'd0;
    w_nib = 4'd0;
    for (int j = 0; j < 8; j++) begin
      w_row = i_sbox[511 - 64*j -: 64];
      w_nib = w_sum[4*j +: 4];
      w_sub[4*j +: 4] = w_row[{~w_nib, 2'b00} +: 4];
    end
    w_f  = {w_sub[20:0], w_sub[31:21]};
    o_n1 = i_n2 ^ w_f;
    o_n2 = i_n1;
  end

endmodule

// File: rtl/gost89_ecb_unit.sv
// Iterative GOST 28147-89 ECB core: one block per load, one round per clock, result 33 edges after load.
module gost89_ecb_unit
  import gost89_pkg::*;
(
  input  logic         clk,
  input  logic         reset_n,
  input  logic         mode,
  input  logic         load_data,
  input  logic [511:0] sbox,
  input  logic [255:0] key,
  input  logic [63:0]  in,
  output logic [63:0]  out,
  output logic         busy
);

  state_t      r_state;
  logic [5:0]  r_cnt;
  logic        r_busy;
  logic        r_mode;
  half_t       r_n1;
  half_t       r_n2;
  block_t      r_out;
  logic [2:0]  w_kidx;
  half_t       w_rkey;
  half_t       w_n1_next;
  half_t       w_n2_next;

  assign w_kidx = key_index(r_cnt[4:0], r_mode);
  // K_j occupies bits [32*(7-j) +: 32].
  assign w_rkey = key[{~w_kidx, 5'b00000} +: 32];

  gost89_round u_round (
    .i_n1   (r_n1),
    .i_n2   (r_n2),
    .i_rkey (w_rkey),
    .i_sbox (sbox),
    .o_n1   (w_n1_next),
    .o_n2   (w_n2_next)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= IDLE;
      r_cnt   <= 6'd0;
      r_busy  <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (load_data) begin
            r_state <= RUN;
            r_cnt   <= 6'd0;
            r_busy  <= 1'b1;
          end
        end
        RUN: begin
          if (r_cnt == LAST_CNT) begin
            r_state <= IDLE;
            r_busy  <= 1'b0;
          end else begin
            r_cnt <= r_cnt + 6'd1;
          end
        end
        default: begin
          r_state <= IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  // Datapath is deliberately unreset: reset only aborts through the FSM, and out keeps its value.
  always_ff @(posedge clk) begin
    if (r_state == IDLE && load_data) begin
      r_n1   <= in[63:32];
      r_n2   <= in[31:0];
      r_mode <= mode;
    end else if (r_state == RUN && r_cnt != LAST_CNT) begin
      r_n1 <= w_n1_next;
      r_n2 <= w_n2_next;
    end
    if (r_state == RUN && r_cnt == LAST_CNT) begin
      r_out <= {r_n2, r_n1};
    end
  end

  assign out  = r_out;
  assign busy = r_busy;

endmodule

// File: tb/tb_gost89_ecb_unit.sv
// Scoreboard bench for gost89_ecb_unit and its fixed-mode wrappers.
module tb_gost89_ecb_unit;

  localparam logic [511:0] SBOX = 512'h4a92d80e6b1c7f53eb4c6dfa23810759581da342efc7609b7da1089fe46cb2536c715fd84a9e03b24ba0721d36859cfedb413f590ae7682c1fd057a4923e6b8c;
  localparam logic [255:0] KEY  = 256'h0475f6e05038fbfad2c7c390edb3ca3d1547124291ae1e8a2f79cd9ed2bcefbd;

  logic         clk = 1'b0;
  logic         reset_n;
  logic         mode;
  logic         load_data;
  logic [511:0] sbox;
  logic [255:0] key;
  logic [63:0]  in;
  logic [63:0]  out;
  logic         busy;
  logic [63:0]  out_enc;
  logic         busy_enc;
  logic [63:0]  out_dec;
  logic         busy_dec;
  logic         load_enc;
  logic         load_dec;

  typedef struct {
    logic [63:0] exp;
    int          due;
    logic        md;
  } exp_t;

  exp_t        sb_q[$];
  int          checks   = 0;
  int          failures = 0;
  int          cycle    = 0;
  logic [63:0] prev_out;

  assign load_enc = load_data & ~mode;
  assign load_dec = load_data & mode;

  always #5 clk = ~clk;

  gost89_ecb_unit dut (
    .clk(clk), .reset_n(reset_n), .mode(mode), .load_data(load_data),
    .sbox(sbox), .key(key), .in(in), .out(out), .busy(busy)
  );

  gost89_ecb_encrypt u_enc (
    .clk(clk), .reset_n(reset_n), .load_data(load_enc),
    .sbox(sbox), .key(key), .in(in), .out(out_enc), .busy(busy_enc)
  );

  gost89_ecb_decrypt u_dec (
    .clk(clk), .reset_n(reset_n), .load_data(load_dec),
    .sbox(sbox), .key(key), .in(in), .out(out_dec), .busy(busy_dec)
  );

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", tag, obs, exp, cycle);
    end
  endtask

  always @(posedge clk) cycle <= cycle + 1;

  // Completion check at the due cycle; any other change of out is an error.
  always @(negedge clk) begin
    if (sb_q.size() > 0 && cycle == sb_q[0].due - 1) begin
      check_eq("busy_run", 64'(busy), 64'd1);
    end
    if (sb_q.size() > 0 && cycle == sb_q[0].due) begin
      check_eq("out", out, sb_q[0].exp);
      check_eq("busy_done", 64'(busy), 64'd0);
      if (sb_q[0].md) check_eq("dec_wrap", out_dec, sb_q[0].exp);
      else            check_eq("enc_wrap", out_enc, sb_q[0].exp);
      void'(sb_q.pop_front());
    end else if (out !== prev_out) begin
      check_eq("out_hold", out, prev_out);
    end
    prev_out <= out;
  end

  task automatic wait_idle();
    int n = 0;
    while (busy && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (busy) check_eq("idle_timeout", 64'(busy), 64'd0);
  endtask

  task automatic send(input logic md, input logic [63:0] din, input logic [63:0] exp);
    wait_idle();
    mode      = md;
    in        = din;
    load_data = 1'b1;
    sb_q.push_back('{exp, cycle + 34, md});
    @(negedge clk);
    load_data = 1'b0;
  endtask

  // Holds reset for n cycles; returns exactly at the negedge where reset_n rises.
  task automatic pulse_reset(input int n, input logic load_in_reset);
    @(negedge clk);
    #2;
    reset_n = 1'b0;
    sb_q.delete();
    #1;
    check_eq("busy_in_reset", 64'(busy), 64'd0);
    if (load_in_reset) begin
      mode      = 1'b0;
      in        = 64'h1122334455667788;
      load_data = 1'b1;
    end
    repeat (n) @(negedge clk);
    load_data = 1'b0;
    reset_n   = 1'b1;
  endtask

  initial begin
    int n;
    reset_n   = 1'b0;
    load_data = 1'b0;
    mode      = 1'b0;
    in        = 64'd0;
    sbox      = SBOX;
    key       = KEY;
    repeat (3) @(negedge clk);
    check_eq("rst_busy", 64'(busy), 64'd0);
    check_eq("rst_busy_enc", 64'(busy_enc), 64'd0);
    reset_n = 1'b1;
    @(negedge clk);

    send(1'b0, 64'hd5a8a608f4f115b4, 64'hd658a36b11cf46eb);
    send(1'b1, 64'hd658a36b11cf46eb, 64'hd5a8a608f4f115b4);

    // Load while busy must be ignored.
    send(1'b0, 64'hd5a8a608f4f115b4, 64'hd658a36b11cf46eb);
    repeat (5) @(negedge clk);
    in        = 64'hffffffffffffffff;
    load_data = 1'b1;
    @(negedge clk);
    load_data = 1'b0;

    wait_idle();
    pulse_reset(3, 1'b0);
    @(negedge clk);
    send(1'b0, 64'h389eb44a391474c4, 64'h7aea1ed18e604249);
    send(1'b1, 64'h7aea1ed18e604249, 64'h389eb44a391474c4);

    // Abort mid-block; also load during reset must not start anything.
    wait_idle();
    send(1'b0, 64'h0123456789abcdef, 64'd0);
    repeat (5) @(negedge clk);
    pulse_reset(2, 1'b1);
    @(negedge clk);
    check_eq("rst_load_ignored", 64'(busy), 64'd0);
    send(1'b0, 64'h379e59c3c96bb2ab, 64'hc35472c91cd78640);
    send(1'b1, 64'hc35472c91cd78640, 64'h379e59c3c96bb2ab);

    // Load on the first edge after reset release.
    wait_idle();
    pulse_reset(2, 1'b0);
    send(1'b0, 64'h3f38ae3b8f541361, 64'h3b5834a000fba066);
    send(1'b1, 64'h3b5834a000fba066, 64'h3f38ae3b8f541361);

    n = 0;
    while (sb_q.size() > 0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    check_eq("drain", 64'(sb_q.size()), 64'd0);
    repeat (3) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
